// File: rtl/add_seq_if.sv
// Handshake and status bundle for the byte-serial add/subtract sequencer.
// master = the glue/pin side driving operands; slave = the sequencer itself.
interface add_seq_if;
   logic       start;
   logic       sub;
   logic       abort;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] res;
   logic       res_valid;
   logic       res_ready;
   logic       carry_out;
   logic       overflow;
   logic       busy;
   logic       done;

   modport master (
      output start, sub, abort, op_a, op_b, in_valid, res_ready,
      input  in_ready, res, res_valid, carry_out, overflow, busy, done
   );

   modport slave (
      input  start, sub, abort, op_a, op_b, in_valid, res_ready,
      output in_ready, res, res_valid, carry_out, overflow, busy, done
   );
endinterface

// File: rtl/add_seq_ctrl.sv
// Byte-serial NBYTES-wide add/subtract sequencer. Operand pairs are buffered
// LSB-first, summed one byte per cycle through a single 8-bit adder with a
// registered carry, and streamed back LSB-first. All outputs are registered.
module add_seq_ctrl #(
   parameter int NBYTES = 4
) (
   input logic      clk,
   input logic      rst_n,
   add_seq_if.slave bus
);
   localparam int            IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
   localparam logic [IW-1:0] ONE_IDX  = IW'(1);
   localparam logic [IW-1:0] ZERO_IDX = IW'(0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t        state_r;
   logic [IW-1:0] idx_r;
   logic          carry_r;
   logic          sub_r;
   logic [7:0]    a_buf_r [NBYTES];
   logic [7:0]    b_buf_r [NBYTES];
   logic [7:0]    res_r;
   logic          res_valid_r;
   logic          in_ready_r;
   logic          carry_out_r;
   logic          overflow_r;
   logic          busy_r;
   logic          done_r;

   logic [8:0]    sum_s;
   logic          ovf_s;
   logic [IW-1:0] idx_nxt_s;
   logic          in_fire_s;
   logic          out_fire_s;

   // One byte of the shared adder; inv turns b into its one's complement for A-B.
   function automatic logic [8:0] add_byte(input logic [7:0] a, input logic [7:0] b,
                                           input logic inv, input logic cin);
      add_byte = {1'b0, a} + {1'b0, b ^ {8{inv}}} + {8'd0, cin};
   endfunction

   // Adder datapath, signed-overflow detect on the current byte, handshake fires.
   always_comb begin
      sum_s      = add_byte(a_buf_r[idx_r], b_buf_r[idx_r], sub_r, carry_r);
      ovf_s      = (a_buf_r[idx_r][7] == (b_buf_r[idx_r][7] ^ sub_r)) &&
                   (sum_s[7] != a_buf_r[idx_r][7]);
      idx_nxt_s  = idx_r + ONE_IDX;
      in_fire_s  = bus.in_valid & in_ready_r;
      out_fire_s = res_valid_r & bus.res_ready;
   end

   // Sequencer FSM with all outputs registered; abort outranks every other event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         idx_r       <= ZERO_IDX;
         carry_r     <= 1'b0;
         sub_r       <= 1'b0;
         res_r       <= 8'd0;
         res_valid_r <= 1'b0;
         in_ready_r  <= 1'b0;
         carry_out_r <= 1'b0;
         overflow_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         for (int i = 0; i < NBYTES; i++) begin
            a_buf_r[i] <= 8'd0;
            b_buf_r[i] <= 8'd0;
         end
      end else if (bus.abort) begin
         state_r     <= IDLE;
         idx_r       <= ZERO_IDX;
         res_r       <= 8'd0;
         res_valid_r <= 1'b0;
         in_ready_r  <= 1'b0;
         carry_out_r <= 1'b0;
         overflow_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  sub_r       <= bus.sub;
                  idx_r       <= ZERO_IDX;
                  carry_out_r <= 1'b0;
                  overflow_r  <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b1;
                  state_r     <= LOAD;
               end
            end
            LOAD: begin
               if (in_fire_s) begin
                  a_buf_r[idx_r] <= bus.op_a;
                  b_buf_r[idx_r] <= bus.op_b;
                  if (idx_r == LAST_IDX) begin
                     idx_r      <= ZERO_IDX;
                     carry_r    <= sub_r;
                     in_ready_r <= 1'b0;
                     state_r    <= CALC;
                  end else begin
                     idx_r <= idx_nxt_s;
                  end
               end
            end
            CALC: begin
               a_buf_r[idx_r] <= sum_s[7:0];
               carry_r        <= sum_s[8];
               if (idx_r == LAST_IDX) begin
                  carry_out_r <= sum_s[8];
                  overflow_r  <= ovf_s;
                  idx_r       <= ZERO_IDX;
                  // Byte 0 was finished NBYTES-1 cycles ago, so it is safe to present now.
                  res_r       <= a_buf_r[0];
                  res_valid_r <= 1'b1;
                  state_r     <= OUT;
               end else begin
                  idx_r <= idx_nxt_s;
               end
            end
            OUT: begin
               if (out_fire_s) begin
                  if (idx_r == LAST_IDX) begin
                     idx_r       <= ZERO_IDX;
                     res_r       <= 8'd0;
                     res_valid_r <= 1'b0;
                     busy_r      <= 1'b0;
                     done_r      <= 1'b1;
                     state_r     <= IDLE;
                  end else begin
                     idx_r <= idx_nxt_s;
                     res_r <= a_buf_r[idx_nxt_s];
                  end
               end
            end
            default: begin
               state_r     <= IDLE;
               idx_r       <= ZERO_IDX;
               res_valid_r <= 1'b0;
               in_ready_r  <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.res       = res_r;
   assign bus.res_valid = res_valid_r;
   assign bus.carry_out = carry_out_r;
   assign bus.overflow  = overflow_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl (NBYTES=4): stimulus pushes expected result
// bytes into a queue, a negedge monitor pops and compares on every res handshake.
module tb_add_seq_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   add_seq_if bus ();

   add_seq_ctrl #(.NBYTES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every accepted result byte must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.res_valid && bus.res_ready) begin
         if (exp_q.size() == 0) begin
            chk("res_unexpected", 32'(bus.res_valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("res_byte", 32'(bus.res), 32'(mon_e));
         end
      end
   end

   task automatic send_pairs(input logic [31:0] a, input logic [31:0] b,
                             input int npairs, input int gap);
      for (int i = 0; i < npairs; i++) begin
         bus.op_a     = a[8*i +: 8];
         bus.op_b     = b[8*i +: 8];
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         if (i < npairs - 1) begin
            repeat (gap) begin
               @(posedge clk); #1;
            end
         end
      end
   endtask

   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int gap, input int stall_k,
                         input bit calc_start, input logic [31:0] r,
                         input logic c, input logic v);
      for (int i = 0; i < 4; i++) exp_q.push_back(r[8*i +: 8]);
      bus.sub   = s;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({nm, "_busy"}, 32'(bus.busy), 32'd1);
      chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      send_pairs(a, b, 4, gap);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         if (calc_start && cyc == 1) begin
            bus.start = 1'b1;
            bus.sub   = ~s;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.sub   = s;
         chk({nm, "_latency"}, 32'(bus.res_valid), (cyc == 4) ? 32'd1 : 32'd0);
      end
      chk({nm, "_carry"}, 32'(bus.carry_out), 32'(c));
      chk({nm, "_ovf"}, 32'(bus.overflow), 32'(v));
      for (int k = 0; k < 4; k++) begin
         if (k == stall_k) begin
            bus.res_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk({nm, "_stall_res"}, 32'(bus.res), 32'(r[8*k +: 8]));
               chk({nm, "_stall_valid"}, 32'(bus.res_valid), 32'd1);
               @(posedge clk); #1;
            end
            bus.res_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      chk({nm, "_done"}, 32'(bus.done), 32'd1);
      chk({nm, "_idle_busy"}, 32'(bus.busy), 32'd0);
      chk({nm, "_idle_valid"}, 32'(bus.res_valid), 32'd0);
      @(posedge clk); #1;
      chk({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
      chk({nm, "_carry_hold"}, 32'(bus.carry_out), 32'(c));
      chk({nm, "_ovf_hold"}, 32'(bus.overflow), 32'(v));
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({nm, "_res"}, 32'(bus.res), 32'd0);
      chk({nm, "_res_valid"}, 32'(bus.res_valid), 32'd0);
      chk({nm, "_carry"}, 32'(bus.carry_out), 32'd0);
      chk({nm, "_ovf"}, 32'(bus.overflow), 32'd0);
      chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
      chk({nm, "_done"}, 32'(bus.done), 32'd0);
   endtask

   // Directed stimulus with hand-computed expectations.
   initial begin
      bus.start     = 1'b0;
      bus.sub       = 1'b0;
      bus.abort     = 1'b0;
      bus.op_a      = 8'd0;
      bus.op_b      = 8'd0;
      bus.in_valid  = 1'b0;
      bus.res_ready = 1'b1;
      #2;
      chk_all_zero("reset");
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("add_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 0, -1, 1'b0, 32'h00000100, 1'b0, 1'b0);
      run_op("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 0, -1, 1'b0, 32'h00000000, 1'b1, 1'b0);
      run_op("add_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 0, -1, 1'b0, 32'h80000000, 1'b0, 1'b1);
      run_op("sub_5_7",    32'h00000005, 32'h00000007, 1'b1, 0, -1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
      run_op("sub_7_5",    32'h00000007, 32'h00000005, 1'b1, 0, -1, 1'b0, 32'h00000002, 1'b1, 1'b0);
      run_op("bp_gap",     32'h000000FF, 32'h00000001, 1'b0, 2, 1,  1'b0, 32'h00000100, 1'b0, 1'b0);
      run_op("calc_start", 32'h00000007, 32'h00000005, 1'b1, 0, -1, 1'b1, 32'h00000002, 1'b1, 1'b0);

      // Abort after two pairs, with a simultaneous start and valid pair.
      bus.sub   = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      send_pairs(32'h11223344, 32'h01010101, 2, 0);
      bus.abort    = 1'b1;
      bus.start    = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.abort    = 1'b0;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      chk_all_zero("abort");
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("abort_no_done", 32'(bus.done), 32'd0);
         chk("abort_no_valid", 32'(bus.res_valid), 32'd0);
      end

      // Reset asserted mid-CALC: outputs must drop without waiting for a clock edge.
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      send_pairs(32'hFFFFFFFF, 32'h00000001, 4, 0);
      @(posedge clk); #1;
      chk("calc_busy", 32'(bus.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_all_zero("rst_after");

      run_op("clean", 32'h12345678, 32'h11111111, 1'b0, 0, -1, 1'b0, 32'h23456789, 1'b0, 1'b0);

      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
